// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache miss fill controller.
// Used by fill_arbiter and cache_fill_ctrl.
package cache_fill_ctrl_pkg;

    // Fill sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // Which cache owns the burst in flight
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Byte-offset bits inside a 16B block; clearing them gives the block base
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'h000F;

    // Bytes per memory word; beat k sits at base + k*WORD_BYTES
    localparam int WORD_BYTES = 2;

endpackage

// File: rtl/fill_arbiter.sv
// Combinational miss arbiter for the fill controller.
// Default build: fixed priority, D-cache wins a simultaneous miss.
// With FILL_ARB_RR_EN defined: the cache that did not win last time wins a tie.
module fill_arbiter
    import cache_fill_ctrl_pkg::*;
(
    input  logic   icache_miss,
    input  logic   dcache_miss,
`ifdef FILL_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   grant_valid,
    output owner_t grant_owner
);

    // Pick a winner from the pending misses
    always_comb begin
        grant_valid = icache_miss | dcache_miss;
        grant_owner = OWN_D;
        if (icache_miss && !dcache_miss) begin
            grant_owner = OWN_I;
        end
`ifdef FILL_ARB_RR_EN
        else if (icache_miss && dcache_miss) begin
            grant_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss fill controller shared by the I-cache and D-cache.
// Grants one miss at a time, issues an 8-beat word burst on the memory read
// port, steers each returned word into the owning cache and pulses its
// fill_done when the block is complete.
// Optional macro FILL_ARB_RR_EN selects round-robin arbitration on a tie.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              icache_fill_we,
    output logic              dcache_fill_we,
    output logic              icache_fill_done,
    output logic              dcache_fill_done,
    output logic              busy
);

    localparam int              CNT_W     = $clog2(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_BLOCK - 1);

    fill_state_t       state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [CNT_W-1:0]  issue_cnt, issue_cnt_nxt;
    logic [CNT_W-1:0]  recv_cnt, recv_cnt_nxt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] grant_base;
    logic              grant_valid;
    owner_t            grant_owner;
    logic              grant_take;
    logic              fill_phase;
    logic              last_recv;

`ifdef FILL_ARB_RR_EN
    owner_t last_owner, last_owner_nxt;
`endif

    // Byte address of beat k within the block at base b (wraps mod 2^ADDR_W)
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [CNT_W-1:0]  k);
        return b + ADDR_W'(k) * ADDR_W'(WORD_BYTES);
    endfunction

    fill_arbiter u_arb (
        .icache_miss (icache_miss),
        .dcache_miss (dcache_miss),
`ifdef FILL_ARB_RR_EN
        .last_owner  (last_owner),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant_base = ((grant_owner == OWN_I) ? icache_miss_addr : dcache_miss_addr)
                        & ~ADDR_W'(BLOCK_OFFSET_MASK);
    assign fill_phase = (state == ISSUE) || (state == DRAIN);
    assign last_recv  = mem_data_valid && (recv_cnt == LAST_BEAT);

    // Control state: FSM, owner, beat counters (async reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_D;
            issue_cnt <= '0;
            recv_cnt  <= '0;
`ifdef FILL_ARB_RR_EN
            last_owner <= OWN_I;
`endif
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            issue_cnt <= issue_cnt_nxt;
            recv_cnt  <= recv_cnt_nxt;
`ifdef FILL_ARB_RR_EN
            last_owner <= last_owner_nxt;
`endif
        end
    end

    // Block base of the granted miss; only meaningful outside IDLE, so no reset
    always_ff @(posedge clk) begin
        if (grant_take) begin
            base <= grant_base;
        end
    end

    // Next-state, counters and all outputs
    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        issue_cnt_nxt    = issue_cnt;
        recv_cnt_nxt     = recv_cnt;
        grant_take       = 1'b0;
        mem_en           = 1'b0;
        mem_addr         = '0;
        fill_addr        = '0;
        fill_data        = '0;
        icache_fill_we   = 1'b0;
        dcache_fill_we   = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        busy             = (state != IDLE);
`ifdef FILL_ARB_RR_EN
        last_owner_nxt   = last_owner;
`endif

        // Returned words are only accepted while a burst is active; anything
        // arriving in IDLE or DONE is a stale response and is dropped.
        if (fill_phase && mem_data_valid) begin
            fill_data    = mem_data_in;
            fill_addr    = beat_addr(base, recv_cnt);
            recv_cnt_nxt = recv_cnt + CNT_W'(1);
            if (owner == OWN_I) begin
                icache_fill_we = 1'b1;
            end else begin
                dcache_fill_we = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    owner_nxt  = grant_owner;
                    state_nxt  = ISSUE;
`ifdef FILL_ARB_RR_EN
                    last_owner_nxt = grant_owner;
`endif
                end
            end
            ISSUE: begin
                mem_en        = 1'b1;
                mem_addr      = beat_addr(base, issue_cnt);
                issue_cnt_nxt = issue_cnt + CNT_W'(1);
                if (issue_cnt == LAST_BEAT) begin
                    // With zero memory latency the last word lands with the last request
                    state_nxt = last_recv ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (last_recv) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (owner == OWN_I) begin
                    icache_fill_done = 1'b1;
                end else begin
                    dcache_fill_done = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
